// File: rtl/range_pkg.sv
// range_pkg: shared sample width, sample type and transmitter state encoding
package range_pkg;
  localparam int RANGE_DATA_W = 10;
  typedef logic [RANGE_DATA_W-1:0] range_sample_t;
  typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;
endpackage

// File: rtl/range_stream_tx_if.sv
// range_stream_tx_if: host write port plus range-finder burst outputs
interface range_stream_tx_if import range_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = RANGE_DATA_W
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_ready;
  logic              start;
  logic              start_err;
  logic              busy;
  logic              done;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] data_out;
  logic              go;
  logic              finish;
  modport master (
    output wr_data, wr_en, start,
    input  wr_ready, start_err, busy, done, count, data_out, go, finish
  );
  modport slave (
    input  wr_data, wr_en, start,
    output wr_ready, start_err, busy, done, count, data_out, go, finish
  );
endinterface

// File: rtl/range_sample_buf.sv
// range_sample_buf: sample register file, one write port, one combinational read port, sync clear
module range_sample_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 10,
  parameter int IW     = 4
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              we,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (clr) mem <= '{default: '0};
    else if (we) mem[wr_idx[AW-1:0]] <= wr_data;
  end
  // the pointer runs one past the last sample on the final SEND cycle
  assign rd_data = rd_idx < IW'(DEPTH) ? mem[rd_idx[AW-1:0]] : '0;
endmodule

// File: rtl/range_stream_tx.sv
// range_stream_tx: buffers host samples and replays them as one go/finish-framed burst
module range_stream_tx import range_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = RANGE_DATA_W
) (
  input logic clock,
  input logic reset,
  range_stream_tx_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  tx_state_t         state, nxt_state;
  logic [CW-1:0]     count, rd_ptr, cnt_nxt, nxt_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_acc, ok_start, last;
  assign bus.wr_ready = state == IDLE && count < CW'(DEPTH);
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == DONE;
  assign bus.count    = count;
  always_comb begin
    wr_acc    = bus.wr_en && bus.wr_ready;
    cnt_nxt   = count + CW'(wr_acc);
    ok_start  = state == IDLE && bus.start && cnt_nxt >= CW'(2);
    last      = rd_ptr == count - CW'(1);
    nxt_state = state == IDLE ? (ok_start ? SEND : IDLE) :
                state == SEND ? (last ? DONE : SEND) : IDLE;
    nxt_ptr   = state == SEND ? rd_ptr + CW'(1) : '0;
  end
  // read at the next pointer so the presented sample lands in a register
  range_sample_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IW(CW)) u_buf (
    .clock   (clock),
    .clr     (reset || state == DONE),
    .we      (wr_acc),
    .wr_idx  (count),
    .wr_data (bus.wr_data),
    .rd_idx  (nxt_ptr),
    .rd_data (rd_data)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      rd_ptr        <= '0;
      bus.data_out  <= '0;
      bus.go        <= 1'b0;
      bus.finish    <= 1'b0;
      bus.start_err <= 1'b0;
    end else begin
      state         <= nxt_state;
      count         <= state == DONE ? '0 : cnt_nxt;
      rd_ptr        <= nxt_ptr;
      bus.data_out  <= nxt_state == SEND ? rd_data : '0;
      bus.go        <= nxt_state == SEND && nxt_ptr == '0;
      bus.finish    <= nxt_state == SEND && nxt_ptr == cnt_nxt - CW'(1);
      bus.start_err <= state == IDLE && bus.start && !ok_start;
    end
  end
endmodule

// File: tb/tb_range_stream_tx.sv
// tb_range_stream_tx: directed checks of buffering, burst framing, refusal and reset
module tb_range_stream_tx;
  import range_pkg::*;
  localparam int DEPTH = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  range_sample_t vals [DEPTH+2] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h001,
                                    10'h200, 10'h0F0, 10'h30F, 10'h123, 10'h321};
  range_stream_tx_if #(.DEPTH(DEPTH), .DATA_W(RANGE_DATA_W)) bus ();
  range_stream_tx #(.DEPTH(DEPTH), .DATA_W(RANGE_DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wr(input range_sample_t v);
    bus.wr_en = 1'b1;
    bus.wr_data = v;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic chk_out(input string tag, input int d, input int g, input int f, input int dn, input int b);
    chk({tag, "_data"}, int'(bus.data_out), d);
    chk({tag, "_go"}, int'(bus.go), g);
    chk({tag, "_finish"}, int'(bus.finish), f);
    chk({tag, "_done"}, int'(bus.done), dn);
    chk({tag, "_busy"}, int'(bus.busy), b);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_out("rst", 0, 0, 0, 0, 0);
    chk("rst_err", int'(bus.start_err), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_ready", int'(bus.wr_ready), 1);
    // basic burst 3,7,1
    wr(10'd3); wr(10'd7); wr(10'd1);
    chk("b_count", int'(bus.count), 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("b1", 3, 1, 0, 0, 1);
    tick();
    chk_out("b2", 7, 0, 0, 0, 1);
    tick();
    chk_out("b3", 1, 0, 1, 0, 1);
    tick();
    chk_out("b4", 0, 0, 0, 1, 1);
    chk("b4_ready", int'(bus.wr_ready), 0);
    tick();
    chk_out("b5", 0, 0, 0, 0, 0);
    chk("b5_count", int'(bus.count), 0);
    chk("b5_ready", int'(bus.wr_ready), 1);
    // refused start with one sample, then a two-sample burst
    wr(10'd5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r_err", int'(bus.start_err), 1);
    chk_out("r1", 0, 0, 0, 0, 0);
    tick();
    chk("r_err_off", int'(bus.start_err), 0);
    chk("r_count", int'(bus.count), 1);
    wr(10'd9);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("r2a", 5, 1, 0, 0, 1);
    tick();
    chk_out("r2b", 9, 0, 1, 0, 1);
    tick();
    chk_out("r2c", 0, 0, 0, 1, 1);
    tick();
    // start together with the second write uses the post-write count
    wr(10'h011);
    bus.wr_en = 1'b1;
    bus.wr_data = 10'h022;
    bus.start = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    chk_out("s1", 'h011, 1, 0, 0, 1);
    chk("s_count", int'(bus.count), 2);
    chk("s_err", int'(bus.start_err), 0);
    tick();
    chk_out("s2", 'h022, 0, 1, 0, 1);
    tick();
    tick();
    // full buffer: extra writes dropped
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr(vals[i]);
      if (i == DEPTH - 1) begin
        chk("f_count_full", int'(bus.count), DEPTH);
        chk("f_ready_full", int'(bus.wr_ready), 0);
      end
    end
    chk("f_count", int'(bus.count), DEPTH);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      chk_out($sformatf("f%0d", k), int'(vals[k]), int'(k == 0), int'(k == DEPTH - 1), 0, 1);
      tick();
    end
    chk_out("f_done", 0, 0, 0, 1, 1);
    tick();
    chk("f_count_end", int'(bus.count), 0);
    // writes and start during SEND are ignored
    wr(10'd10); wr(10'd20); wr(10'd30); wr(10'd40);
    bus.start = 1'b1;
    tick();
    chk_out("w1", 10, 1, 0, 0, 1);
    bus.wr_en = 1'b1;
    bus.wr_data = 10'd99;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    chk_out("w2", 20, 0, 0, 0, 1);
    chk("w_count", int'(bus.count), 4);
    tick();
    chk_out("w3", 30, 0, 0, 0, 1);
    tick();
    chk_out("w4", 40, 0, 1, 0, 1);
    tick();
    chk_out("w5", 0, 0, 0, 1, 1);
    tick();
    chk_out("w6", 0, 0, 0, 0, 0);
    chk("w6_count", int'(bus.count), 0);
    tick();
    chk_out("w7", 0, 0, 0, 0, 0);
    // reset in the middle of a five-sample burst
    for (int i = 1; i <= 5; i++) wr(range_sample_t'(i));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("m1", 1, 1, 0, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("m2", 0, 0, 0, 0, 0);
    chk("m2_count", int'(bus.count), 0);
    chk("m2_ready", int'(bus.wr_ready), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("m%0d", k + 3), 0, 0, 0, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
